// File: rtl/sprite_pkg.sv
// Shared screen constants, position-FSM states and ROM artwork pattern for the tile sprite engine.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;

  typedef enum logic {
    IDLE,
    PENDING
  } pos_state_t;

  // Built-in artwork: an address hash, so neighbouring words differ and zero words exist.
  function automatic logic [31:0] rom_pattern(input logic [31:0] addr);
    return addr ^ (addr >> 8) ^ (addr >> 16);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous sprite ROM: address registered in, colour out one cycle later.
// Contents come from the package artwork pattern; output clears on reset.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_data <= '0;
    else       o_data <= DATA_W'(rom_pattern(32'(i_addr)));
  end

endmodule

// File: rtl/tile_sprite_engine.sv
// Movable, optionally self-scrolling sprite: hit test + multiplier-free ROM addressing, output 2 cycles after scan.
// Position updates are held pending until frame start; build option SPRITE_TRANSPARENCY_EN keys out one colour.
module tile_sprite_engine
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 471,
  parameter int SPR_H       = 250,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int INIT_X      = 80,
  parameter int INIT_Y      = 112,
  parameter int SCREEN_H    = V_ACTIVE,
  parameter int SCROLL_STEP = 4
`ifdef SPRITE_TRANSPARENCY_EN
  ,
  parameter logic [DATA_W-1:0] TRANSPARENT_KEY = DATA_W'(8'h00)
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_xx,
  input  logic [COORD_W-1:0] i_yy,
  input  logic               i_aactive,
  input  logic               i_frame_start,
  input  logic [COORD_W-1:0] i_pos_x,
  input  logic [COORD_W-1:0] i_pos_y,
  input  logic               i_pos_valid,
  output logic               o_pos_ready,
  input  logic               i_scroll_en,
  output logic               o_sprite_on,
  output logic [DATA_W-1:0]  o_dataout,
  output logic               o_wrap
);

  localparam int CW1 = COORD_W + 1;

  pos_state_t         state, state_nxt;
  logic               take_req, commit;
  logic [COORD_W-1:0] pos_x, pos_y, pend_x, pend_y;
  logic [COORD_W:0]   y_sum, x_end, y_end;
  logic               do_scroll, y_wraps;
  logic               hit, first_row, last_col;
  logic [ADDR_W-1:0]  row_base, row_base_cur, addr_nxt, addr_q;
  logic               hit_d1, hit_d2, opaque;
  logic [DATA_W-1:0]  rom_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_pos_ready = 1'b0;
    take_req    = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        o_pos_ready = 1'b1;
        if (i_pos_valid) begin
          take_req  = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (i_frame_start) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_x <= '0;
      pend_y <= '0;
    end else if (take_req) begin
      pend_x <= i_pos_x;
      pend_y <= i_pos_y;
    end
  end

  // A commit owns the frame boundary; scrolling only moves an already-settled sprite.
  assign y_sum     = {1'b0, pos_y} + CW1'(SCROLL_STEP);
  assign y_wraps   = (y_sum >= CW1'(SCREEN_H));
  assign do_scroll = i_frame_start & i_scroll_en & ~commit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_x  <= COORD_W'(INIT_X);
      pos_y  <= COORD_W'(INIT_Y);
      o_wrap <= 1'b0;
    end else begin
      o_wrap <= do_scroll & y_wraps;
      if (commit) begin
        pos_x <= pend_x;
        pos_y <= pend_y;
      end else if (do_scroll) begin
        pos_y <= y_wraps ? COORD_W'(y_sum - CW1'(SCREEN_H)) : y_sum[COORD_W-1:0];
      end
    end
  end

  // One extra bit on the far edges lets rectangles hang off-screen without wrapping around.
  assign x_end     = {1'b0, pos_x} + CW1'(SPR_W);
  assign y_end     = {1'b0, pos_y} + CW1'(SPR_H);
  assign hit       = i_aactive & (i_xx >= pos_x) & ({1'b0, i_xx} < x_end)
                               & (i_yy >= pos_y) & ({1'b0, i_yy} < y_end);
  assign first_row = (i_yy == pos_y);
  assign last_col  = ({1'b0, i_xx} == x_end - CW1'(1));

  assign row_base_cur = first_row ? '0 : row_base;
  assign addr_nxt     = row_base_cur + ADDR_W'(i_xx - pos_x);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q   <= '0;
      row_base <= '0;
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
    end else begin
      hit_d1 <= hit;
      hit_d2 <= hit_d1;
      if (hit) begin
        addr_q <= addr_nxt;
        if (last_col)       row_base <= row_base_cur + ADDR_W'(SPR_W);
        else if (first_row) row_base <= '0;
      end
    end
  end

  sprite_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (addr_q),
    .o_data (rom_q)
  );

`ifdef SPRITE_TRANSPARENCY_EN
  assign opaque = (rom_q != TRANSPARENT_KEY);
`else
  assign opaque = 1'b1;
`endif

  assign o_sprite_on = hit_d2 & opaque;
  assign o_dataout   = o_sprite_on ? rom_q : '0;

endmodule

// File: tb/tb_tile_sprite_engine.sv
// Self-checking bench for tile_sprite_engine: directed scenarios plus randomised frames
// checked against a geometric model (address = row * width + column).
module tb_tile_sprite_engine;

  localparam int SW = 471;
  localparam int SH = 250;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [9:0] i_xx = '0, i_yy = '0, i_pos_x = '0, i_pos_y = '0;
  logic       i_aactive = 1'b0, i_frame_start = 1'b0, i_pos_valid = 1'b0, i_scroll_en = 1'b0;
  logic       o_pos_ready, o_sprite_on, o_wrap;
  logic [7:0] o_dataout;

  int checks = 0;
  int fails  = 0;

  tile_sprite_engine dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_xx          (i_xx),
    .i_yy          (i_yy),
    .i_aactive     (i_aactive),
    .i_frame_start (i_frame_start),
    .i_pos_x       (i_pos_x),
    .i_pos_y       (i_pos_y),
    .i_pos_valid   (i_pos_valid),
    .o_pos_ready   (o_pos_ready),
    .i_scroll_en   (i_scroll_en),
    .o_sprite_on   (o_sprite_on),
    .o_dataout     (o_dataout),
    .o_wrap        (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] rom_ref(input int a);
    logic [31:0] v;
    v = a ^ (a >> 8) ^ (a >> 16);
    return v[7:0];
  endfunction

  function automatic bit vis_ref(input int a);
`ifdef SPRITE_TRANSPARENCY_EN
    return rom_ref(a) != 8'h00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one scan pixel, then idle; outputs for that pixel are visible on return.
  task automatic probe(input int x, input int y, input bit act);
    i_xx      = 10'(x);
    i_yy      = 10'(y);
    i_aactive = act;
    step();
    i_aactive = 1'b0;
    step();
  endtask

  task automatic set_pos(input int x, input int y);
    i_pos_x     = 10'(x);
    i_pos_y     = 10'(y);
    i_pos_valid = 1'b1;
    step();
    i_pos_valid   = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    if (o_pos_ready !== 1'b1) begin $display("FAIL reset_ready: got %0b want 1", o_pos_ready); fails++; end
    checks++;
    if (o_sprite_on !== 1'b0) begin $display("FAIL reset_on: got %0b want 0", o_sprite_on); fails++; end
    checks++;
    if (o_dataout !== 8'h00) begin $display("FAIL reset_data: got %h want 00", o_dataout); fails++; end
    checks++;
    if (o_wrap !== 1'b0) begin $display("FAIL reset_wrap: got %0b want 0", o_wrap); fails++; end
    checks++;
    step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_static();
    int tx[5]  = '{80, 337, 550, 551, 80};
    int ty[5]  = '{112, 112, 112, 112, 113};
    int ta[5]  = '{0, 257, 470, -1, 471};
    int ux[4]  = '{550, 80, 79, 300};
    int uy[4]  = '{361, 362, 200, 200};
    bit uact[4] = '{1, 1, 1, 0};
    int ua[4]  = '{117749, -1, -1, -1};
    bit eon;
    logic [7:0] ed;
    int a;
    for (int k = 0; k < 5; k++) begin
      probe(tx[k], ty[k], 1'b1);
      eon = (ta[k] >= 0) && vis_ref(ta[k]);
      ed  = eon ? rom_ref(ta[k]) : 8'h00;
      if (o_sprite_on !== eon || o_dataout !== ed) begin
        $display("FAIL static_a (%0d,%0d): on=%0b dat=%h want on=%0b dat=%h", tx[k], ty[k], o_sprite_on, o_dataout, eon, ed);
        fails++;
      end
      checks++;
    end
    for (int y = 113; y <= 360; y++) begin
      probe(550, y, 1'b1);
      a   = (y - 112) * SW + 470;
      eon = vis_ref(a);
      ed  = eon ? rom_ref(a) : 8'h00;
      if (o_sprite_on !== eon || o_dataout !== ed) begin
        $display("FAIL static_rows y=%0d: on=%0b dat=%h want on=%0b dat=%h", y, o_sprite_on, o_dataout, eon, ed);
        fails++;
      end
      checks++;
    end
    for (int k = 0; k < 4; k++) begin
      probe(ux[k], uy[k], uact[k]);
      eon = (ua[k] >= 0) && vis_ref(ua[k]);
      ed  = eon ? rom_ref(ua[k]) : 8'h00;
      if (o_sprite_on !== eon || o_dataout !== ed) begin
        $display("FAIL static_b (%0d,%0d): on=%0b dat=%h want on=%0b dat=%h", ux[k], uy[k], o_sprite_on, o_dataout, eon, ed);
        fails++;
      end
      checks++;
    end
  endtask

  task automatic test_pos_request();
    i_pos_x     = 10'd200;
    i_pos_y     = 10'd300;
    i_pos_valid = 1'b1;
    if (o_pos_ready !== 1'b1) begin $display("FAIL req_ready_idle: got %0b want 1", o_pos_ready); fails++; end
    checks++;
    step();
    i_pos_valid = 1'b0;
    if (o_pos_ready !== 1'b0) begin $display("FAIL req_ready_drop: got %0b want 0", o_pos_ready); fails++; end
    checks++;
    probe(80, 112, 1'b1);
    if (o_sprite_on !== vis_ref(0)) begin $display("FAIL req_old_pos: got %0b want %0b", o_sprite_on, vis_ref(0)); fails++; end
    checks++;
    probe(600, 400, 1'b1);
    if (o_sprite_on !== 1'b0) begin $display("FAIL req_new_early: got %0b want 0", o_sprite_on); fails++; end
    checks++;
    // A second request while pending must be ignored.
    i_pos_x     = 10'd10;
    i_pos_y     = 10'd10;
    i_pos_valid = 1'b1;
    step();
    step();
    if (o_pos_ready !== 1'b0) begin $display("FAIL req_pending_ready: got %0b want 0", o_pos_ready); fails++; end
    checks++;
    i_pos_valid   = 1'b0;
    i_frame_start = 1'b1;
    if (o_pos_ready !== 1'b0) begin $display("FAIL req_ready_at_fs: got %0b want 0", o_pos_ready); fails++; end
    checks++;
    step();
    i_frame_start = 1'b0;
    if (o_pos_ready !== 1'b1) begin $display("FAIL req_ready_rise: got %0b want 1", o_pos_ready); fails++; end
    checks++;
    probe(201, 300, 1'b1);
    if (o_sprite_on !== 1'b1 || o_dataout !== rom_ref(1)) begin
      $display("FAIL req_new_hit: on=%0b dat=%h want on=1 dat=%h", o_sprite_on, o_dataout, rom_ref(1)); fails++;
    end
    checks++;
    probe(80, 112, 1'b1);
    if (o_sprite_on !== 1'b0) begin $display("FAIL req_old_gone: got %0b want 0", o_sprite_on); fails++; end
    checks++;
    probe(10, 10, 1'b1);
    if (o_sprite_on !== 1'b0) begin $display("FAIL req_ignored: got %0b want 0", o_sprite_on); fails++; end
    checks++;
  endtask

  task automatic test_scroll();
    int ys[3]   = '{478, 2, 6};
    int yoff[3] = '{477, 478, 5};
    bit ew[3]   = '{0, 1, 0};
    i_scroll_en = 1'b1;
    i_pos_x     = 10'd80;
    i_pos_y     = 10'd478;
    i_pos_valid = 1'b1;
    step();
    i_pos_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_frame_start = 1'b1;
      step();
      i_frame_start = 1'b0;
      if (o_wrap !== ew[k]) begin $display("FAIL scroll_wrap f%0d: got %0b want %0b", k, o_wrap, ew[k]); fails++; end
      checks++;
      step();
      if (o_wrap !== 1'b0) begin $display("FAIL scroll_wrap_pulse f%0d: got %0b want 0", k, o_wrap); fails++; end
      checks++;
      probe(81, ys[k], 1'b1);
      if (o_sprite_on !== 1'b1 || o_dataout !== rom_ref(1)) begin
        $display("FAIL scroll_top f%0d: on=%0b dat=%h want on=1 dat=%h", k, o_sprite_on, o_dataout, rom_ref(1)); fails++;
      end
      checks++;
      probe(81, yoff[k], 1'b1);
      if (o_sprite_on !== 1'b0) begin $display("FAIL scroll_off f%0d: got %0b want 0", k, o_sprite_on); fails++; end
      checks++;
    end
    i_scroll_en = 1'b0;
  endtask

  task automatic test_clip();
    int cx[4]  = '{81, 81, 100, 100};
    int cy[4]  = '{400, 10, 169, 479};
    bit con[4] = '{1, 0, 0, 1};
    set_pos(80, 400);
    for (int k = 0; k < 4; k++) begin
      probe(cx[k], cy[k], 1'b1);
      if (o_sprite_on !== con[k]) begin
        $display("FAIL clip (%0d,%0d): got %0b want %0b", cx[k], cy[k], o_sprite_on, con[k]); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_reset_pending();
    i_pos_x     = 10'd600;
    i_pos_y     = 10'd10;
    i_pos_valid = 1'b1;
    step();
    i_pos_valid = 1'b0;
    if (o_pos_ready !== 1'b0) begin $display("FAIL rstp_pending: got %0b want 0", o_pos_ready); fails++; end
    checks++;
    i_xx = 10'd81; i_yy = 10'd400; i_aactive = 1'b1;
    step();
    i_aactive = 1'b0;
    step();
    if (o_sprite_on !== 1'b1) begin $display("FAIL rstp_inflight: got %0b want 1", o_sprite_on); fails++; end
    checks++;
    #2 i_rst = 1'b1;
    #1;
    if (o_pos_ready !== 1'b1 || o_sprite_on !== 1'b0 || o_dataout !== 8'h00) begin
      $display("FAIL rstp_async: ready=%0b on=%0b dat=%h want 1 0 00", o_pos_ready, o_sprite_on, o_dataout); fails++;
    end
    checks++;
    #2 i_rst = 1'b0;
    step();
    probe(81, 112, 1'b1);
    if (o_sprite_on !== 1'b1 || o_dataout !== rom_ref(1)) begin
      $display("FAIL rstp_home: on=%0b dat=%h want on=1 dat=%h", o_sprite_on, o_dataout, rom_ref(1)); fails++;
    end
    checks++;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    probe(601, 10, 1'b1);
    if (o_sprite_on !== 1'b0) begin $display("FAIL rstp_discard: got %0b want 0", o_sprite_on); fails++; end
    checks++;
    probe(81, 112, 1'b1);
    if (o_sprite_on !== 1'b1) begin $display("FAIL rstp_kept: got %0b want 1", o_sprite_on); fails++; end
    checks++;
  endtask

  task automatic test_random();
    int px, py, ylast, y0, a;
    int xs[$];
    bit acts[$];
    bit qon[$];
    logic [7:0] qd[$];
    bit eon, in_spr;
    logic [7:0] ed;
    for (int f = 0; f < 4; f++) begin
      px = $urandom_range(0, 169);
      py = $urandom_range(0, 479);
      set_pos(px, py);
      qon.delete();
      qd.delete();
      ylast = (py + SH - 1 > 479) ? 479 : py + SH - 1;
      y0    = (py > 0) ? py - 1 : py;
      for (int y = y0; y <= ylast; y++) begin
        int r1, r2;
        xs.delete();
        acts.delete();
        r1 = $urandom_range(1, 469);
        r2 = $urandom_range(r1, 469);
        if (px > 0) begin xs.push_back($urandom_range(0, px - 1)); acts.push_back(1'b1); end
        xs.push_back(px);          acts.push_back(1'b1);
        xs.push_back(px + r1);     acts.push_back($urandom_range(0, 3) != 0);
        xs.push_back(px + r2);     acts.push_back($urandom_range(0, 3) != 0);
        xs.push_back(px + SW - 1); acts.push_back(1'b1);
        if (px + SW <= 639) begin xs.push_back($urandom_range(px + SW, 639)); acts.push_back(1'b1); end
        foreach (xs[k]) begin
          in_spr = acts[k] && xs[k] >= px && xs[k] < px + SW && y >= py && y < py + SH;
          a      = (y - py) * SW + (xs[k] - px);
          eon    = in_spr && vis_ref(a);
          ed     = eon ? rom_ref(a) : 8'h00;
          i_xx      = 10'(xs[k]);
          i_yy      = 10'(y);
          i_aactive = acts[k];
          qon.push_back(eon);
          qd.push_back(ed);
          step();
          if (qon.size() == 2) begin
            if (o_sprite_on !== qon[0] || o_dataout !== qd[0]) begin
              $display("FAIL random f%0d y%0d: on=%0b dat=%h want on=%0b dat=%h", f, y, o_sprite_on, o_dataout, qon[0], qd[0]);
              fails++;
            end
            checks++;
            void'(qon.pop_front());
            void'(qd.pop_front());
          end
        end
      end
      i_aactive = 1'b0;
      qon.push_back(1'b0);
      qd.push_back(8'h00);
      step();
      if (o_sprite_on !== qon[0] || o_dataout !== qd[0]) begin
        $display("FAIL random_tail f%0d: on=%0b dat=%h want on=%0b dat=%h", f, o_sprite_on, o_dataout, qon[0], qd[0]);
        fails++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pos_request();
    test_scroll();
    test_clip();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
